// File: rtl/scope_capture_ctrl_if.sv
// Drained-sample stream from the capture controller toward the display/host path.
// master = controller (produces samples), slave = consumer (applies backpressure).
interface scope_capture_ctrl_if #(
  parameter int DW = 8
);
  logic [DW-1:0] out_data;
  logic [2:0]    out_ch;
  logic          out_valid;
  logic          out_ready;

  modport master (output out_data, output out_ch, output out_valid, input out_ready);
  modport slave  (input out_data, input out_ch, input out_valid, output out_ready);
endinterface

// File: rtl/scope_capture_ctrl.sv
// One-shot acquisition sequencer: clear FIFOs, run ADCs, level-crossing trigger,
// post-trigger capture, then round-robin drain of all channel FIFOs onto one stream.
//
// state     | meaning
// S_IDLE    | waiting for arm, config registers hold last latched values
// S_CLEAR   | fifo_sclr held for CLR_CYCLES cycles, ADCs stopped
// S_PRIME   | ADCs running, first sample seeds the previous-sample register
// S_WAIT_TRIG | ADCs running, looking for the level crossing on the selected channel
// S_POST    | ADCs running, counting post-trigger samples
// S_DRAIN   | ADCs stopped, FIFOs emptied round-robin onto the output stream
// S_DONE    | one-cycle done pulse
module scope_capture_ctrl #(
  parameter int N_CH       = 4,
  parameter int DW         = 8,
  parameter int CW         = 10,
  parameter int CLR_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic               abort,
  input  logic [2:0]         trig_sel,
  input  logic [DW-1:0]      trig_level,
  input  logic               trig_edge,
  input  logic [CW-1:0]      post_cnt,
  input  logic               live_valid,
  input  logic [N_CH*DW-1:0] live_data,
  input  logic [N_CH-1:0]    fifo_empty,
  input  logic [N_CH*DW-1:0] fifo_q,
  output logic [N_CH-1:0]    fifo_rdreq,
  output logic               fifo_sclr,
  output logic               adc_bg,
  output logic               busy,
  output logic               done,
  scope_capture_ctrl_if.master stream
);

  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int KW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_PRIME, S_WAIT_TRIG, S_POST, S_DRAIN, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    sel_q;
  logic [DW-1:0] level_q;
  logic          edge_q;
  logic [CW-1:0] post_q;
  logic [KW-1:0] clr_left;
  logic [CW-1:0] post_left;
  logic [DW-1:0] prev_q;
  logic [PW-1:0] ptr;

  logic [DW-1:0] cur;
  logic [DW-1:0] head;
  logic          head_empty;
  logic          trig_hit;
  logic [PW-1:0] ptr_wrap;
  logic          out_valid_c;
  logic          xfer;
  logic [N_CH-1:0] rdreq_c;
  logic          arm_ok;

  always_comb begin
    cur        = '0;
    head       = '0;
    head_empty = 1'b1;
    for (int k = 0; k < N_CH; k++) begin
      if (sel_q == 3'(k)) cur = live_data[k*DW +: DW];
      if (ptr == PW'(k)) begin
        head       = fifo_q[k*DW +: DW];
        head_empty = fifo_empty[k];
      end
    end
  end

  assign trig_hit = edge_q ? ((prev_q < level_q) && (cur >= level_q))
                           : ((prev_q > level_q) && (cur <= level_q));
  assign ptr_wrap = (ptr == PW'(N_CH - 1)) ? '0 : ptr + 1'b1;
  assign arm_ok   = (state == S_IDLE) && arm && !abort;

  always_comb begin
    state_nxt   = state;
    fifo_sclr   = 1'b0;
    adc_bg      = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    out_valid_c = 1'b0;
    xfer        = 1'b0;
    rdreq_c     = '0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (arm_ok) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        fifo_sclr = 1'b1;
        if (clr_left == '0) state_nxt = S_PRIME;
      end
      S_PRIME: begin
        adc_bg = 1'b1;
        if (live_valid) state_nxt = S_WAIT_TRIG;
      end
      S_WAIT_TRIG: begin
        adc_bg = 1'b1;
        if (live_valid && trig_hit) state_nxt = (post_q == '0) ? S_DRAIN : S_POST;
      end
      S_POST: begin
        adc_bg = 1'b1;
        if (live_valid && (post_left <= CW'(1))) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        out_valid_c = !head_empty;
        xfer        = out_valid_c && stream.out_ready && !abort;
        for (int k = 0; k < N_CH; k++) rdreq_c[k] = xfer && (ptr == PW'(k));
        if (&fifo_empty) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) state_nxt = S_IDLE;
  end

  assign fifo_rdreq       = rdreq_c;
  assign stream.out_valid = out_valid_c;
  assign stream.out_data  = (state == S_DRAIN) ? head : '0;
  assign stream.out_ch    = (state == S_DRAIN) ? 3'(ptr) : 3'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      sel_q     <= '0;
      level_q   <= '0;
      edge_q    <= 1'b0;
      post_q    <= '0;
      clr_left  <= '0;
      post_left <= '0;
      prev_q    <= '0;
      ptr       <= '0;
    end else begin
      state <= state_nxt;
      if (arm_ok) begin
        sel_q    <= trig_sel;
        level_q  <= trig_level;
        edge_q   <= trig_edge;
        post_q   <= post_cnt;
        clr_left <= KW'(CLR_CYCLES - 1);
      end
      if ((state == S_CLEAR) && (clr_left != '0)) clr_left <= clr_left - 1'b1;
      if (live_valid && ((state == S_PRIME) || (state == S_WAIT_TRIG))) prev_q <= cur;
      if ((state == S_WAIT_TRIG) && live_valid && trig_hit) post_left <= post_q;
      // saturating: a zero count never wraps back to the top
      if ((state == S_POST) && live_valid && (post_left != '0)) post_left <= post_left - 1'b1;
      if (state != S_DRAIN) ptr <= '0;
      else if (!abort && (head_empty || xfer)) ptr <= ptr_wrap;
    end
  end

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Self-checking bench for scope_capture_ctrl: behavioural show-ahead FIFOs plus a
// scoreboard of expected drained words in round-robin order.
module tb_scope_capture_ctrl;
  localparam int N_CH = 4;
  localparam int DW   = 8;
  localparam int CW   = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arm = 1'b0;
  logic abort = 1'b0;
  logic [2:0] trig_sel = 3'd2;
  logic [DW-1:0] trig_level = '0;
  logic trig_edge = 1'b0;
  logic [CW-1:0] post_cnt = '0;
  logic live_valid = 1'b0;
  logic [N_CH*DW-1:0] live_data = '0;
  logic [N_CH-1:0] fifo_empty = '1;
  logic [N_CH*DW-1:0] fifo_q = '0;
  logic [N_CH-1:0] fifo_rdreq;
  logic fifo_sclr, adc_bg, busy, done;

  scope_capture_ctrl_if #(.DW(DW)) s ();

  scope_capture_ctrl #(.N_CH(N_CH), .DW(DW), .CW(CW), .CLR_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort),
    .trig_sel(trig_sel), .trig_level(trig_level), .trig_edge(trig_edge),
    .post_cnt(post_cnt), .live_valid(live_valid), .live_data(live_data),
    .fifo_empty(fifo_empty), .fifo_q(fifo_q), .fifo_rdreq(fifo_rdreq),
    .fifo_sclr(fifo_sclr), .adc_bg(adc_bg), .busy(busy), .done(done),
    .stream(s)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fq [N_CH][$];
  logic [10:0]   exp_q [$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // FIFO model: clear/pop on the clock edge, outputs refreshed just after the falling edge
  always @(posedge clk) begin
    for (int k = 0; k < N_CH; k++) begin
      if (fifo_sclr) fq[k].delete();
      else if (fifo_rdreq[k] && (fq[k].size() > 0)) void'(fq[k].pop_front());
    end
  end

  always @(negedge clk) begin
    #1;
    for (int k = 0; k < N_CH; k++) begin
      fifo_empty[k]       = (fq[k].size() == 0);
      fifo_q[k*DW +: DW]  = (fq[k].size() > 0) ? fq[k][0] : '0;
    end
  end

  // output monitor / scoreboard
  logic [10:0] mon_e;
  logic [10:0] held;
  logic        stall = 1'b0;
  logic [3:0]  exp_rd;
  always @(negedge clk) begin
    #2;
    if (rst) stall = 1'b0;
    else begin
      if (stall && s.out_valid) chk_val("hold", {s.out_ch, s.out_data}, held);
      if (abort && busy) chk_val("abort_rdreq", fifo_rdreq, 0);
      else if (s.out_valid && s.out_ready) begin
        if (exp_q.size() == 0) chk_val("sb_extra", 1, 0);
        else begin
          mon_e  = exp_q.pop_front();
          exp_rd = 4'(1) << mon_e[10:8];
          chk_val("out_word", {s.out_ch, s.out_data}, mon_e);
          chk_val("rdreq", fifo_rdreq, exp_rd);
        end
      end else chk_val("rdreq_idle", fifo_rdreq, 0);
      stall = s.out_valid && !s.out_ready;
      held  = {s.out_ch, s.out_data};
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] v);
    live_data        = $urandom;
    live_data[23:16] = v;
    live_valid       = 1'b1;
    tick();
    live_valid       = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic set_cfg(input logic [7:0] lvl, input logic e, input logic [9:0] pc);
    trig_sel   = 3'd2;
    trig_level = lvl;
    trig_edge  = e;
    post_cnt   = pc;
  endtask

  task automatic wait_adc(input int lim);
    bit seen;
    seen = 0;
    for (int i = 0; i < lim; i++) begin
      if (adc_bg) begin seen = 1; break; end
      tick();
    end
    chk_val("adc_on", 32'(seen), 1);
  endtask

  task automatic wait_done(input int lim, input bit toggle);
    bit seen;
    seen = 0;
    for (int i = 0; i < lim; i++) begin
      if (done) begin seen = 1; break; end
      if (toggle) s.out_ready = ~s.out_ready;
      tick();
    end
    chk_val("done_pulse", 32'(seen), 1);
    if (seen) begin
      chk_val("busy_in_done", busy, 0);
      tick();
      chk_val("done_one_cycle", done, 0);
      chk_val("idle_after_done", busy, 0);
    end
    s.out_ready = 1'b1;
  endtask

  // loads words and pushes the expected round-robin drain order
  task automatic load_fifos(input int c0, input int c1, input int c2, input int c3);
    int c [4];
    int rd [4];
    logic [7:0] w [4][8];
    logic [7:0] d;
    bit any;
    c = '{c0, c1, c2, c3};
    for (int k = 0; k < 4; k++) begin
      rd[k] = 0;
      for (int j = 0; j < c[k]; j++) begin
        d = 8'($urandom);
        fq[k].push_back(d);
        w[k][j] = d;
      end
    end
    any = 1;
    while (any) begin
      any = 0;
      for (int k = 0; k < 4; k++) begin
        if (rd[k] < c[k]) begin
          exp_q.push_back({3'(k), w[k][rd[k]]});
          rd[k]++;
          any = 1;
        end
      end
    end
  endtask

  function automatic int fifo_total();
    int t;
    t = 0;
    for (int k = 0; k < N_CH; k++) t += fq[k].size();
    return t;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    s.out_ready = 1'b1;
    repeat (3) tick();
    chk_val("rst_busy", busy, 0);
    chk_val("rst_adc", adc_bg, 0);
    chk_val("rst_sclr", fifo_sclr, 0);
    chk_val("rst_done", done, 0);
    chk_val("rst_valid", s.out_valid, 0);
    chk_val("rst_rdreq", fifo_rdreq, 0);
    chk_val("rst_ch", s.out_ch, 0);
    rst = 1'b0;
    tick();

    // clear phase length; arm and config changes while busy are ignored
    set_cfg(8'h80, 1'b1, 10'd3);
    pulse_arm();
    for (int i = 0; i < 4; i++) begin
      chk_val("sclr_on", fifo_sclr, 1);
      chk_val("adc_off_clear", adc_bg, 0);
      chk_val("busy_clear", busy, 1);
      if (i == 1) begin
        arm = 1'b1; trig_level = 8'h10; trig_edge = 1'b0; post_cnt = '0;
      end else arm = 1'b0;
      tick();
    end
    arm = 1'b0;
    chk_val("sclr_off", fifo_sclr, 0);
    chk_val("adc_prime", adc_bg, 1);

    // equal-to-level samples never trigger, ramp triggers on 0x80
    send(8'h80);
    for (int i = 0; i < 4; i++) begin
      send(8'h80);
      chk_val("no_trig_equal", adc_bg, 1);
    end
    send(8'h70);
    send(8'h7F);
    chk_val("no_trig_below", adc_bg, 1);
    load_fifos(2, 0, 1, 2);
    send(8'h80);
    tick();
    send(8'h55);
    chk_val("post1", adc_bg, 1);
    send(8'h20);
    chk_val("post2", adc_bg, 1);
    send(8'h99);
    chk_val("post_end_adc", adc_bg, 0);
    chk_val("post_end_busy", busy, 1);
    wait_done(100, 1'b0);
    chk_val("sb_drained1", exp_q.size(), 0);
    chk_val("fifo_empty1", fifo_total(), 0);

    // falling edge with zero post samples, ready toggling during drain
    set_cfg(8'h80, 1'b0, 10'd0);
    pulse_arm();
    wait_adc(20);
    send(8'h90);
    load_fifos(3, 1, 2, 0);
    s.out_ready = 1'b0;
    send(8'h80);
    chk_val("post0_drain", adc_bg, 0);
    chk_val("post0_busy", busy, 1);
    wait_done(100, 1'b1);
    chk_val("sb_drained2", exp_q.size(), 0);
    chk_val("fifo_empty2", fifo_total(), 0);

    // abort mid-drain
    set_cfg(8'h80, 1'b1, 10'd1);
    pulse_arm();
    wait_adc(20);
    send(8'h00);
    load_fifos(2, 2, 2, 2);
    send(8'h90);
    send(8'h11);
    chk_val("drain_entry", adc_bg, 0);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_val("abort_idle", busy, 0);
    chk_val("abort_valid", s.out_valid, 0);
    chk_val("abort_left", fifo_total(), 5);
    seen = 0;
    repeat (5) begin
      seen |= done;
      tick();
    end
    chk_val("no_done_abort", 32'(seen), 0);
    exp_q.delete();

    // abort wins over arm in idle
    arm = 1'b1;
    abort = 1'b1;
    tick();
    arm = 1'b0;
    abort = 1'b0;
    chk_val("abort_arm_idle", busy, 0);
    chk_val("abort_arm_sclr", fifo_sclr, 0);

    // next arm clears leftover data
    set_cfg(8'h80, 1'b1, 10'd5);
    pulse_arm();
    chk_val("rearm_sclr", fifo_sclr, 1);
    wait_adc(20);
    chk_val("fifos_cleared", fifo_total(), 0);

    // asynchronous reset during post capture
    send(8'h00);
    send(8'hC0);
    chk_val("post_running", adc_bg, 1);
    send(8'h01);
    #1 rst = 1'b1;
    #1;
    chk_val("async_adc", adc_bg, 0);
    chk_val("async_busy", busy, 0);
    chk_val("async_sclr", fifo_sclr, 0);
    tick();
    rst = 1'b0;
    tick();
    pulse_arm();
    chk_val("clean_clear", fifo_sclr, 1);
    chk_val("clean_busy", busy, 1);
    wait_adc(20);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_val("final_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
